ex_issue_stage: RTL
===================

# ex_issue_stage

Decode-to-execute pipeline register for the core's execute stage. It captures one decoded instruction, resolves operand forwarding from the MEM and WB stages, and drives the operand and `ALUControlE` inputs of the execute-stage ALU. It holds multiply operations stable for a fixed number of cycles before issuing them. It handles stall (valid/ready) and flush, so the ALU always sees a well-defined operation.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE`` (32): datapath width.
- `REG_ADDR_W`, default 5: register-index width.
- `MUL_LATENCY`, default 3, must be ≥1: cycles a MUL must stay stable at the ALU inputs before it issues.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  decode offers an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_alu_ctrl`  in  3  funct3-style op (`ADD_FUNCT3`, `SUB_FUNCT3`, `MUL_FUNCT3`, `AND_FUNCT3`, `OR_FUNCT3`).
- `in_rs1`, `in_rs2`, `in_rd`  in  REG_ADDR_W each  source and destination indices.
- `in_rs1_data`, `in_rs2_data`, `in_imm`  in  WORD_SIZE each  register-file reads and immediate.
- `in_use_imm`  in  1  operand b comes from the immediate.
- `in_reg_write`  in  1  instruction writes `rd`.
- `flush`  in  1  kill the held instruction (branch redirect).
- `mem_fwd_en`, `mem_fwd_rd`, `mem_fwd_data`  in  1/REG_ADDR_W/WORD_SIZE  MEM-stage result.
- `wb_fwd_en`, `wb_fwd_rd`, `wb_fwd_data`  in  1/REG_ADDR_W/WORD_SIZE  WB-stage result.
- `out_ready`  in  1  EX/MEM can take the issued operation.
- `a_e`, `b_e`  out  WORD_SIZE each  ALU operands.
- `ALUControlE`  out  3  ALU op.
- `fire_e`  out  1  the operation on `a_e`/`b_e`/`ALUControlE` issues this cycle.
- `rd_e`  out  REG_ADDR_W  destination of the held instruction.
- `reg_write_e`  out  1  held instruction writes `rd_e`.

## Operation
- States:
  - EMPTY: nothing is held.
  - FULL: a non-MUL instruction is held.
  - MUL_WAIT: a MUL is held and `mul_cnt` is counting.
- Accept when `in_valid && in_ready && !flush`. This latches every `in_*` field. The next state is MUL_WAIT when `in_alu_ctrl == MUL_FUNCT3` (with `mul_cnt` set to 0); otherwise FULL.
- `in_ready = (state==EMPTY) || (fire_e && out_ready)`. Back-to-back issue is allowed.
- `fire_e`:
  - FULL: `fire_e = 1`.
  - MUL_WAIT: `fire_e = (mul_cnt == MUL_LATENCY-1)`.
  - EMPTY: `fire_e = 0`.
- `mul_cnt` increments each MUL_WAIT cycle and saturates at MUL_LATENCY-1.
- Transfer happens on `fire_e && out_ready`. With no simultaneous accept, the stage goes to EMPTY.
- Stall (`fire_e && !out_ready`) holds all state and outputs.
- Forwarding applies per source operand, with the held index rsN:
  - MEM match (`mem_fwd_en && mem_fwd_rd==rsN && rsN!=0`) beats WB match; a WB match beats the held value.
  - Result is applied combinationally to `a_e`/`b_e`.
  - Every FULL/MUL_WAIT cycle the forwarded value is also written back into the held operand register, so it persists after the producer leaves MEM/WB.
- `b_e = held_imm` when `held_use_imm`, else the forwarded/held rs2 value. Forwarding still updates the held rs2 value.
- Index 0 never forwards; its held value is used as delivered (the register file supplies 0).
- `flush` clears the stage to EMPTY, clears `mul_cnt` and drops any same-cycle `in_valid`. It overrides accept and transfer.
- Outputs in EMPTY: `a_e`, `b_e` = 0; `ALUControlE = ADD_FUNCT3`; `fire_e`, `reg_write_e` = 0; `rd_e` = 0.

## Timing
- Reset: `rst` sampled high at a rising edge gives state EMPTY, all held fields 0 and `mul_cnt` 0. All outputs read the EMPTY values in the following cycle. Reset mid-MUL abandons the operation with no fire.
- Latency:
  - Non-MUL: accepted at edge N, `fire_e` high in cycle N+1.
  - MUL: `fire_e` high in cycle N+MUL_LATENCY.
- The ALU registers its result, so EX/MEM sees it one cycle after `fire_e`.
- While in MUL_WAIT, `a_e`, `b_e` and `ALUControlE` change only through forwarding.
- Transfer with `in_valid` in the same cycle: the new instruction is latched at that edge, with no bubble.
- `flush` together with `fire_e && out_ready`: the transfer is suppressed and `reg_write_e` is already 0 in the next cycle.
- Forward source matching in the same cycle as accept: the captured `in_rsN_data` is used, not the forward. Forwarding starts the cycle after accept.

## Test plan
- Reset, then ADD rs1=1 (10), rs2=2 (5) → `fire_e` in cycle 1, `a_e`=10, `b_e`=5, `ALUControlE`=ADD; `in_ready` stays high for a back-to-back SUB.
- MUL 7×6 with MUL_LATENCY=3 → `fire_e` low for 2 cycles, high on the 3rd; `in_ready` low until then; a SUB offered meanwhile is accepted on the issue edge.
- Held ADD rs1=3; MEM forwards rd=3 with 0x55 and WB forwards rd=3 with 0x99 together → `a_e`=0x55. With `out_ready`=0 and the forwards removed next cycle, `a_e` stays 0x55.
- Forward to rd=0 with 0xFF while rs1=0 → `a_e` keeps the held value 0.
- `flush` during MUL_WAIT cycle 2 with `in_valid`=1 → EMPTY next cycle, `fire_e` never asserted, offered instruction not latched.
- `rst` asserted while a stalled OR is held → next cycle `fire_e`=0, `a_e`=`b_e`=0, `ALUControlE`=ADD, `in_ready`=1.

Source files
------------

// File: rtl/ex_issue_stage.sv
// Decode-to-execute issue register: holds one decoded instruction, forwards from MEM/WB,
// and keeps MUL operands stable for MUL_LATENCY cycles before issuing them to the ALU.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADD_FUNCT3
`define ADD_FUNCT3 3'b000
`endif
`ifndef SUB_FUNCT3
`define SUB_FUNCT3 3'b001
`endif
`ifndef MUL_FUNCT3
`define MUL_FUNCT3 3'b010
`endif
`ifndef OR_FUNCT3
`define OR_FUNCT3 3'b110
`endif
`ifndef AND_FUNCT3
`define AND_FUNCT3 3'b111
`endif

// state    | meaning
// EMPTY    | nothing held, outputs parked at zero / ADD
// FULL     | non-MUL instruction held, issues every cycle until transferred
// MUL_WAIT | MUL held, mul_cnt counts up to MUL_LATENCY-1 before issue
module ex_issue_stage #(
    parameter int WORD_SIZE   = `WORD_SIZE,
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_alu_ctrl,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [WORD_SIZE-1:0]  in_rs1_data,
    input  logic [WORD_SIZE-1:0]  in_rs2_data,
    input  logic [WORD_SIZE-1:0]  in_imm,
    input  logic                  in_use_imm,
    input  logic                  in_reg_write,
    input  logic                  flush,
    input  logic                  mem_fwd_en,
    input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
    input  logic [WORD_SIZE-1:0]  mem_fwd_data,
    input  logic                  wb_fwd_en,
    input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
    input  logic [WORD_SIZE-1:0]  wb_fwd_data,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  a_e,
    output logic [WORD_SIZE-1:0]  b_e,
    output logic [2:0]            ALUControlE,
    output logic                  fire_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic                  reg_write_e
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, MUL_WAIT = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [2:0]            h_ctrl;
    logic [REG_ADDR_W-1:0] h_rs1, h_rs2, h_rd;
    logic [WORD_SIZE-1:0]  h_rs1_data, h_rs2_data, h_imm;
    logic                  h_use_imm, h_reg_write;
    logic [CNT_W-1:0]      mul_cnt;
    logic [WORD_SIZE-1:0]  fwd_a, fwd_b;
    logic                  accept, xfer;

    // MEM has priority over WB; register 0 never forwards
    always_comb begin
        fwd_a = h_rs1_data;
        if (wb_fwd_en && wb_fwd_rd == h_rs1 && h_rs1 != '0)
            fwd_a = wb_fwd_data;
        if (mem_fwd_en && mem_fwd_rd == h_rs1 && h_rs1 != '0)
            fwd_a = mem_fwd_data;
        fwd_b = h_rs2_data;
        if (wb_fwd_en && wb_fwd_rd == h_rs2 && h_rs2 != '0)
            fwd_b = wb_fwd_data;
        if (mem_fwd_en && mem_fwd_rd == h_rs2 && h_rs2 != '0)
            fwd_b = mem_fwd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            h_ctrl      <= '0;
            h_rs1       <= '0;
            h_rs2       <= '0;
            h_rd        <= '0;
            h_rs1_data  <= '0;
            h_rs2_data  <= '0;
            h_imm       <= '0;
            h_use_imm   <= 1'b0;
            h_reg_write <= 1'b0;
            mul_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                mul_cnt <= '0;
            end else if (accept) begin
                h_ctrl      <= in_alu_ctrl;
                h_rs1       <= in_rs1;
                h_rs2       <= in_rs2;
                h_rd        <= in_rd;
                h_rs1_data  <= in_rs1_data;
                h_rs2_data  <= in_rs2_data;
                h_imm       <= in_imm;
                h_use_imm   <= in_use_imm;
                h_reg_write <= in_reg_write;
                mul_cnt     <= '0;
            end else if (state != EMPTY) begin
                // keep forwarded values once the producer has left MEM/WB
                h_rs1_data <= fwd_a;
                h_rs2_data <= fwd_b;
                if (state == MUL_WAIT && mul_cnt != CNT_LAST)
                    mul_cnt <= mul_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        accept    = in_valid && in_ready && !flush;
        xfer      = fire_e && out_ready;
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = (in_alu_ctrl == `MUL_FUNCT3) ? MUL_WAIT : FULL;
        else if (xfer)
            state_nxt = EMPTY;
    end

    always_comb begin
        fire_e      = 1'b0;
        a_e         = '0;
        b_e         = '0;
        ALUControlE = `ADD_FUNCT3;
        rd_e        = '0;
        reg_write_e = 1'b0;
        case (state)
            FULL:     fire_e = 1'b1;
            MUL_WAIT: fire_e = (mul_cnt == CNT_LAST);
            default:  fire_e = 1'b0;
        endcase
        if (state != EMPTY) begin
            a_e         = fwd_a;
            b_e         = h_use_imm ? h_imm : fwd_b;
            ALUControlE = h_ctrl;
            rd_e        = h_rd;
            reg_write_e = h_reg_write;
        end
        in_ready = (state == EMPTY) || (fire_e && out_ready);
    end

endmodule
